// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop synchronized, mid-bit sampled 8N2 (configurable) deframer with a
// valid/ready byte port. Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_core #(
    parameter int unsigned BAUD_2_CLOCK_RATIO = 1250,
    parameter int unsigned UART_DATA_BITS     = 8,
    parameter int unsigned UART_STOP_BITS     = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          UART_PARITY_ODD    = 1'b0
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      parity_err,
    output logic                      busy
);

    localparam int unsigned CntW = $clog2(BAUD_2_CLOCK_RATIO);
    localparam int unsigned BitW = $clog2(UART_DATA_BITS);

    localparam logic [CntW-1:0] CntReload = CntW'(BAUD_2_CLOCK_RATIO - 1);
    localparam logic [CntW-1:0] CntHalf   = CntW'(BAUD_2_CLOCK_RATIO / 2 - 1);
    localparam logic [BitW-1:0] LastBit   = BitW'(UART_DATA_BITS - 1);
    localparam logic            LastStop  = 1'(UART_STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e                    state_q, state_d;
    logic                      rx_meta_q, rx_s_q, rx_prev_q;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [BitW-1:0]           bit_idx_q, bit_idx_d;
    logic                      stop_idx_q, stop_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] dout_q, dout_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      strobe, fall, deliver;

    // Synchronizer and edge-detect flops idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall   = rx_prev_q & ~rx_s_q;
    assign strobe = (state_q != StIdle) && (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
`endif

        if (state_q != StIdle) begin
            cnt_d = strobe ? CntReload : cnt_q - 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = CntHalf;
                end
            end
            StStart: begin
                if (strobe) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (strobe) begin
                    shift_d   = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LastBit) begin
                        stop_idx_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d    = StParity;
`else
                        state_d    = StStop;
`endif
                    end
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (strobe) begin
                    par_bad_d = (^shift_q) ^ rx_s_q ^ UART_PARITY_ODD;
                    state_d   = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                if (strobe) begin
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end else if (stop_idx_q == LastStop) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register: a delivery coinciding with an accept replaces the byte in place.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver) begin
            if (!valid_q || dout_ready) begin
                dout_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // A parity error still delivers the byte; the flag accompanies the delivery cycle.
    assign parity_err_d = deliver & par_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames scored against
// a byte-level model of the UART line protocol.
module tb_uart_rx_core;

    localparam int unsigned Baud = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, frame_err, overrun, parity_err, busy;

    uart_rx_core #(
        .BAUD_2_CLOCK_RATIO(Baud),
        .UART_DATA_BITS    (8),
        .UART_STOP_BITS    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vld_cnt = 0, rise_cyc = 0;
    logic        vld_prev = 1'b0;
    logic [7:0]  got_q[$];
    int unsigned n_checks = 0, n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (overrun)    ov_cnt <= ov_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (dout_valid) vld_cnt <= vld_cnt + 1;
        if (dout_valid && !vld_prev) rise_cyc <= cyc;
        if (dout_valid && dout_ready) got_q.push_back(dout);
        vld_prev <= dout_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(Baud);
    endtask

    // par < 0: no parity bit on the wire.
    task automatic send_frame(input logic [7:0] d, input logic s1, input logic s2, input int par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par >= 0) drive_bit(par[0]);
        drive_bit(s1);
        drive_bit(s2);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned base, fe0, ov0, pe0, v0, t0, bad_n, gap, r;
        logic [7:0]  exp_q[$];
        logic [7:0]  d;
        logic        s1, s2;

        // Reset state
        #12;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {frame_err, overrun, parity_err}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);

        // Single byte, consumer always ready
        dout_ready = 1'b1;
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; v0 = vld_cnt;
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        tick(8);
        check("a5_count", got_q.size(), base + 1);
        if (got_q.size() > base) check("a5_data", got_q[base], 8'hA5);
        // Second stop bit centre on the wire is 168 clk after the start edge.
        check("a5_latency", (rise_cyc - t0 >= 169) && (rise_cyc - t0 <= 173), 1);
        check("a5_valid_len", vld_cnt - v0, 1);
        check("a5_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

        // Back-to-back bytes with the consumer stalled
        dout_ready = 1'b0;
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        tick(8);
        check("ovr_dout", dout, 8'h3C);
        check("ovr_valid", dout_valid, 1);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_no_fe", fe_cnt - fe0, 0);
        dout_ready = 1'b1;
        tick(3);
        check("ovr_valid_drop", dout_valid, 0);
        check("ovr_count", got_q.size(), base + 1);
        if (got_q.size() > base) check("ovr_data", got_q[base], 8'h3C);

        // Framing error, then a long break, then a clean byte
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        tick(100);
        check("fe_pulses", fe_cnt - fe0, 1);
        check("fe_valid", dout_valid, 0);
        check("fe_no_byte", got_q.size(), base);
        check("fe_busy_break", busy, 1);
        rx = 1'b1;
        tick(4);
        send_frame(8'h01, 1'b1, 1'b1, -1);
        tick(8);
        check("brk_count", got_q.size(), base + 1);
        if (got_q.size() > base) check("brk_data", got_q[base], 8'h01);
        check("brk_fe_once", fe_cnt - fe0, 1);
        check("fe_no_ovr", ov_cnt - ov0, 0);

        // Short low glitch from idle
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cnt;
        rx = 1'b0;
        tick(6);
        rx = 1'b1;
        check("gl_busy_seen", busy, 1);
        for (int i = 0; i < 40 && busy; i++) tick(1);
        check("gl_busy_clear", busy, 0);
        check("gl_no_valid", vld_cnt - v0, 0);
        check("gl_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        tick(4);

        // Asynchronous reset in the middle of a frame
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        check("mid_busy", busy, 1);
        check("mid_dout_held", dout, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_busy", busy, 0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        base = got_q.size();
        send_frame(8'h12, 1'b1, 1'b1, -1);
        tick(8);
        check("post_rst_count", got_q.size(), base + 1);
        if (got_q.size() > base) check("post_rst_data", got_q[base], 8'h12);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so a 0 parity bit is wrong and a 1 is right
        base = got_q.size(); pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        tick(8);
        check("par_bad_pulse", pe_cnt - pe0, 1);
        if (got_q.size() > base) check("par_bad_data", got_q[base], 8'h07);
        base = got_q.size(); pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1);
        tick(8);
        check("par_ok_pulse", pe_cnt - pe0, 0);
        if (got_q.size() > base) check("par_ok_data", got_q[base], 8'h07);
`endif

        // Randomized frames: bytes with both stop bits high arrive in order, others flag
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        bad_n = 0;
        for (int f = 0; f < 24; f++) begin
            d  = 8'($urandom);
            r  = $urandom_range(0, 5);
            s1 = (r != 0) && (r != 2);
            s2 = (r != 1) && (r != 2);
            if (s1 && s2) exp_q.push_back(d);
            else bad_n++;
`ifdef UART_RX_PARITY_EN
            send_frame(d, s1, s2, int'(^d));
`else
            send_frame(d, s1, s2, -1);
`endif
            rx = 1'b1;
            gap = (s1 && s2) ? $urandom_range(0, 12) : $urandom_range(4, 12);
            if (gap > 0) tick(gap);
        end
        tick(10);
        check("rnd_count", got_q.size() - base, exp_q.size());
        check("rnd_fe", fe_cnt - fe0, bad_n);
        check("rnd_ovr", ov_cnt - ov0, 0);
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            check($sformatf("rnd_data_%0d", i), got_q[base + i], exp_q[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
